hpi_access_ctrl: RTL

HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

---
 rtl/hpi_access_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hpi_access_ctrl.sv
// HPI bus access controller: turns single-word host requests into timed
// CS/R/W strobe sequences, issues HPI chip resets, and holds a keycode bank.
module hpi_access_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RST_CYC    = 8,
  parameter int NKEYS      = 6,
  localparam int KI_W      = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,

  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 req_ready,

  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,

  input  logic                 hpi_rst_req,
  output logic                 busy,

  output logic [ADDR_W-1:0]    otg_hpi_address,
  output logic                 otg_hpi_cs_n,
  output logic                 otg_hpi_r_n,
  output logic                 otg_hpi_w_n,
  output logic                 otg_hpi_reset_n,
  output logic [DATA_W-1:0]    otg_hpi_data_out,
  output logic                 otg_hpi_data_oe,
  input  logic [DATA_W-1:0]    otg_hpi_data_in,

  input  logic                 kc_we,
  input  logic [KI_W-1:0]      kc_idx,
  input  logic [7:0]           kc_data,
  output logic [8*NKEYS-1:0]   keycode
);

  localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CD  = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4,
    HRST   = 3'd5
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rst_pending;
  logic                accept;
  logic                sample_rd;
  logic                clr_rd;

  // Address and write data come straight from the latched request, so the
  // bus values are stable across SETUP..HOLD and zero while in reset.
  assign otg_hpi_address  = addr_q;
  assign otg_hpi_data_out = wdata_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rst_pending <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // A reset request arriving mid-transfer waits until the bus is idle.
      if (state_d == HRST)
        rst_pending <= 1'b0;
      else if (hpi_rst_req && state != IDLE && state != HRST)
        rst_pending <= 1'b1;
      if (sample_rd)
        rsp_rdata <= otg_hpi_data_in;
      else if (clr_rd)
        rsp_rdata <= '0;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    accept          = 1'b0;
    sample_rd       = 1'b0;
    clr_rd          = 1'b0;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    busy            = 1'b1;
    otg_hpi_cs_n    = 1'b1;
    otg_hpi_r_n     = 1'b1;
    otg_hpi_w_n     = 1'b1;
    otg_hpi_reset_n = 1'b1;
    otg_hpi_data_oe = 1'b0;

    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = !rst_pending && !hpi_rst_req;
        if (rst_pending || hpi_rst_req) begin
          state_d = HRST;
          cnt_d   = CNT_W'(RST_CYC - 1);
        end else if (req_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end

      SETUP: begin
        otg_hpi_cs_n    = 1'b0;
        otg_hpi_data_oe = wr_q;
        if (cnt == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      STROBE: begin
        otg_hpi_cs_n    = 1'b0;
        otg_hpi_r_n     = wr_q;
        otg_hpi_w_n     = !wr_q;
        otg_hpi_data_oe = wr_q;
        if (cnt == '0) begin
          sample_rd = !wr_q;
          state_d   = HOLD;
          cnt_d     = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      HOLD: begin
        otg_hpi_cs_n    = 1'b0;
        otg_hpi_data_oe = wr_q;
        if (cnt == '0) begin
          clr_rd  = wr_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end

      HRST: begin
        otg_hpi_reset_n = 1'b0;
        if (cnt == '0)
          state_d = IDLE;
        else
          cnt_d = cnt - 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // Keycode bank runs independently of the bus FSM; out-of-range slots
  // simply match no entry.
  // NOTE: this small register bank is reset because its contents are
  // visible on the keycode port straight out of reset.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      keycode <= '0;
    end else if (kc_we) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (kc_idx == KI_W'(i))
          keycode[8*i +: 8] <= kc_data;
      end
    end
  end

endmodule
